// File: rtl/reg_file_pkg.sv
// Shared types and constants for the architectural register file with rename tags.
package reg_file_pkg;
  localparam int REG_NUM   = 32;
  localparam int REG_POS_W = 5;
  localparam int DATA_W    = 32;
  localparam int ROB_POS_W = 4;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  typedef logic [REG_POS_W-1:0] reg_pos_t;
  typedef logic [DATA_W-1:0]    data_t;
  typedef logic [ROB_POS_W-1:0] rob_pos_t;
  typedef logic [ROB_POS_W:0]   rob_wrap_pos_t;
endpackage

// File: rtl/reg_file_read_port.sv
// Combinational operand read for one source register, with bypass from the commit in flight.
module reg_read_port
  import reg_file_pkg::*;
#(
  parameter int DATA_W    = reg_file_pkg::DATA_W,
  parameter int ROB_POS_W = reg_file_pkg::ROB_POS_W
) (
  input  logic [4:0]           rs,
  input  logic [DATA_W-1:0]    stored_val,
  input  logic                 stored_busy,
  input  logic [ROB_POS_W:0]   stored_tag,
  input  logic                 commit_en,
  input  logic [4:0]           commit_rd,
  input  logic [DATA_W-1:0]    commit_val,
  input  logic [ROB_POS_W:0]   commit_pos,
  output logic [DATA_W-1:0]    val,
  output logic                 busy,
  output logic [ROB_POS_W:0]   tag
);

  logic bypass_hit;

  // The ROB entry disappears at commit, so a matching commit must be forwarded here.
  assign bypass_hit = commit_en && (commit_rd == rs) && stored_busy && (stored_tag == commit_pos);

  always_comb begin
    val  = stored_val;
    busy = stored_busy;
    tag  = stored_tag;
    if (rs == '0) begin
      val  = '0;
      busy = FALSE;
      tag  = '0;
    end else if (bypass_hit) begin
      val  = commit_val;
      busy = FALSE;
      tag  = '0;
    end
  end

endmodule

// File: rtl/reg_file.sv
// Architectural register file with busy flags and ROB producer tags.
// Optional retired-write counter enabled by defining REG_FILE_COMMIT_CNT_EN.
module reg_file
  import reg_file_pkg::*;
#(
  parameter int DATA_W    = reg_file_pkg::DATA_W,
  parameter int ROB_POS_W = reg_file_pkg::ROB_POS_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic                 clr,
  input  logic                 rob_to_reg_enable,
  input  logic [4:0]           rob_to_reg_rd,
  input  logic [DATA_W-1:0]    rob_to_reg_val,
  input  logic [ROB_POS_W:0]   commit_rob_pos,
  input  logic                 issue_to_reg_enable,
  input  logic [4:0]           issue_to_reg_rd,
  input  logic [ROB_POS_W:0]   issue_to_reg_rob_pos,
  input  logic [4:0]           dc_to_reg_rs1,
  input  logic [4:0]           dc_to_reg_rs2,
  output logic [DATA_W-1:0]    reg_to_dc_rs1_val,
  output logic [DATA_W-1:0]    reg_to_dc_rs2_val,
  output logic                 reg_to_dc_rs1_busy,
  output logic                 reg_to_dc_rs2_busy,
  output logic [ROB_POS_W:0]   reg_to_dc_rs1_rob_pos,
  output logic [ROB_POS_W:0]   reg_to_dc_rs2_rob_pos,
  output logic [31:0]          dbg_commit_cnt
);

  logic [DATA_W-1:0]  val_q  [REG_NUM];
  logic               busy_q [REG_NUM];
  logic [ROB_POS_W:0] tag_q  [REG_NUM];

  logic commit_wr;
  logic issue_wr;

  assign commit_wr = rob_to_reg_enable && (rob_to_reg_rd != '0);
  assign issue_wr  = issue_to_reg_enable && (issue_to_reg_rd != '0) && !clr;

  // Commit is applied first so that a same-cycle issue or flush overrides busy/tag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < REG_NUM; i++) begin
        val_q[i]  <= '0;
        busy_q[i] <= FALSE;
        tag_q[i]  <= '0;
      end
    end else if (rdy) begin
      if (commit_wr) begin
        val_q[rob_to_reg_rd] <= rob_to_reg_val;
        if (busy_q[rob_to_reg_rd] && (tag_q[rob_to_reg_rd] == commit_rob_pos)) begin
          busy_q[rob_to_reg_rd] <= FALSE;
          tag_q[rob_to_reg_rd]  <= '0;
        end
      end
      if (clr) begin
        for (int i = 0; i < REG_NUM; i++) begin
          busy_q[i] <= FALSE;
          tag_q[i]  <= '0;
        end
      end else if (issue_wr) begin
        busy_q[issue_to_reg_rd] <= TRUE;
        tag_q[issue_to_reg_rd]  <= issue_to_reg_rob_pos;
      end
    end
  end

`ifdef REG_FILE_COMMIT_CNT_EN
  logic [31:0] commit_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      commit_cnt_q <= '0;
    end else if (rdy && commit_wr) begin
      commit_cnt_q <= commit_cnt_q + 32'd1;
    end
  end

  assign dbg_commit_cnt = commit_cnt_q;
`else
  assign dbg_commit_cnt = '0;
`endif

  reg_read_port #(.DATA_W(DATA_W), .ROB_POS_W(ROB_POS_W)) u_rs1 (
    .rs          (dc_to_reg_rs1),
    .stored_val  (val_q[dc_to_reg_rs1]),
    .stored_busy (busy_q[dc_to_reg_rs1]),
    .stored_tag  (tag_q[dc_to_reg_rs1]),
    .commit_en   (rob_to_reg_enable),
    .commit_rd   (rob_to_reg_rd),
    .commit_val  (rob_to_reg_val),
    .commit_pos  (commit_rob_pos),
    .val         (reg_to_dc_rs1_val),
    .busy        (reg_to_dc_rs1_busy),
    .tag         (reg_to_dc_rs1_rob_pos)
  );

  reg_read_port #(.DATA_W(DATA_W), .ROB_POS_W(ROB_POS_W)) u_rs2 (
    .rs          (dc_to_reg_rs2),
    .stored_val  (val_q[dc_to_reg_rs2]),
    .stored_busy (busy_q[dc_to_reg_rs2]),
    .stored_tag  (tag_q[dc_to_reg_rs2]),
    .commit_en   (rob_to_reg_enable),
    .commit_rd   (rob_to_reg_rd),
    .commit_val  (rob_to_reg_val),
    .commit_pos  (commit_rob_pos),
    .val         (reg_to_dc_rs2_val),
    .busy        (reg_to_dc_rs2_busy),
    .tag         (reg_to_dc_rs2_rob_pos)
  );

endmodule

// File: tb/tb_reg_file.sv
// Directed self-checking bench for reg_file (honours REG_FILE_COMMIT_CNT_EN when defined).
module tb_reg_file;

`ifdef REG_FILE_COMMIT_CNT_EN
  localparam int CNT_EN = 1;
`else
  localparam int CNT_EN = 0;
`endif

  logic        clk = 1'b0;
  logic        rst, rdy, clr;
  logic        rob_to_reg_enable;
  logic [4:0]  rob_to_reg_rd;
  logic [31:0] rob_to_reg_val;
  logic [4:0]  commit_rob_pos;
  logic        issue_to_reg_enable;
  logic [4:0]  issue_to_reg_rd;
  logic [4:0]  issue_to_reg_rob_pos;
  logic [4:0]  dc_to_reg_rs1, dc_to_reg_rs2;
  logic [31:0] rs1_val, rs2_val;
  logic        rs1_busy, rs2_busy;
  logic [4:0]  rs1_tag, rs2_tag;
  logic [31:0] dbg_commit_cnt;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  reg_file dut (
    .clk                  (clk),
    .rst                  (rst),
    .rdy                  (rdy),
    .clr                  (clr),
    .rob_to_reg_enable    (rob_to_reg_enable),
    .rob_to_reg_rd        (rob_to_reg_rd),
    .rob_to_reg_val       (rob_to_reg_val),
    .commit_rob_pos       (commit_rob_pos),
    .issue_to_reg_enable  (issue_to_reg_enable),
    .issue_to_reg_rd      (issue_to_reg_rd),
    .issue_to_reg_rob_pos (issue_to_reg_rob_pos),
    .dc_to_reg_rs1        (dc_to_reg_rs1),
    .dc_to_reg_rs2        (dc_to_reg_rs2),
    .reg_to_dc_rs1_val    (rs1_val),
    .reg_to_dc_rs2_val    (rs2_val),
    .reg_to_dc_rs1_busy   (rs1_busy),
    .reg_to_dc_rs2_busy   (rs2_busy),
    .reg_to_dc_rs1_rob_pos(rs1_tag),
    .reg_to_dc_rs2_rob_pos(rs2_tag),
    .dbg_commit_cnt       (dbg_commit_cnt)
  );

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    clr = 0;
    rob_to_reg_enable = 0; rob_to_reg_rd = 0; rob_to_reg_val = 0; commit_rob_pos = 0;
    issue_to_reg_enable = 0; issue_to_reg_rd = 0; issue_to_reg_rob_pos = 0;
  endtask

  task automatic issue(input logic [4:0] rd, input logic [4:0] tag);
    issue_to_reg_enable = 1; issue_to_reg_rd = rd; issue_to_reg_rob_pos = tag;
  endtask

  task automatic commit(input logic [4:0] rd, input logic [31:0] v, input logic [4:0] tag);
    rob_to_reg_enable = 1; rob_to_reg_rd = rd; rob_to_reg_val = v; commit_rob_pos = tag;
  endtask

  initial begin
    rst = 0; rdy = 1; idle_inputs();
    dc_to_reg_rs1 = 0; dc_to_reg_rs2 = 0;
    step(); step();
    rst = 1;
    dc_to_reg_rs1 = 5; #1;
    chk("reset_val", rs1_val, 0);
    chk("reset_busy", {31'd0, rs1_busy}, 0);
    chk("reset_tag", {27'd0, rs1_tag}, 0);
    chk("reset_cnt", dbg_commit_cnt, 0);

    // Issue then commit on x3
    issue(5'd3, 5'b10010); step(); idle_inputs();
    dc_to_reg_rs1 = 3; #1;
    chk("iss3_busy", {31'd0, rs1_busy}, 1);
    chk("iss3_tag", {27'd0, rs1_tag}, 32'b10010);
    commit(5'd3, 32'hDEAD, 5'b10010); #1;
    chk("byp3_val", rs1_val, 32'hDEAD);
    chk("byp3_busy", {31'd0, rs1_busy}, 0);
    chk("byp3_tag", {27'd0, rs1_tag}, 0);
    step(); idle_inputs(); #1;
    chk("st3_val", rs1_val, 32'hDEAD);
    chk("st3_busy", {31'd0, rs1_busy}, 0);
    chk("cnt_1", dbg_commit_cnt, 1 * CNT_EN);

    // Rename race on x7
    issue(5'd7, 5'b10001); step();
    issue(5'd7, 5'b10100); step(); idle_inputs();
    dc_to_reg_rs2 = 7;
    commit(5'd7, 32'd1, 5'b10001); #1;
    chk("race_nobyp_val", rs2_val, 0);
    chk("race_nobyp_busy", {31'd0, rs2_busy}, 1);
    step(); idle_inputs(); #1;
    chk("race_val", rs2_val, 1);
    chk("race_busy", {31'd0, rs2_busy}, 1);
    chk("race_tag", {27'd0, rs2_tag}, 32'b10100);
    commit(5'd7, 32'd2, 5'b10100); #1;
    chk("race_byp_val", rs2_val, 2);
    step(); idle_inputs(); #1;
    chk("race2_val", rs2_val, 2);
    chk("race2_busy", {31'd0, rs2_busy}, 0);
    chk("race2_tag", {27'd0, rs2_tag}, 0);
    chk("cnt_3", dbg_commit_cnt, 3 * CNT_EN);

    // Tag compare must include the wrap MSB
    issue(5'd8, 5'b10010); step(); idle_inputs();
    dc_to_reg_rs1 = 8;
    commit(5'd8, 32'd3, 5'b00010); #1;
    chk("msb_nobyp_busy", {31'd0, rs1_busy}, 1);
    step(); idle_inputs(); #1;
    chk("msb_val", rs1_val, 3);
    chk("msb_busy", {31'd0, rs1_busy}, 1);
    chk("msb_tag", {27'd0, rs1_tag}, 32'b10010);

    // Same-cycle issue + commit on x4
    issue(5'd4, 5'b10000); step(); idle_inputs();
    dc_to_reg_rs1 = 4;
    commit(5'd4, 32'd9, 5'b10000); issue(5'd4, 5'b10011); #1;
    chk("same_byp_val", rs1_val, 9);
    chk("same_byp_busy", {31'd0, rs1_busy}, 0);
    step(); idle_inputs(); #1;
    chk("same_val", rs1_val, 9);
    chk("same_busy", {31'd0, rs1_busy}, 1);
    chk("same_tag", {27'd0, rs1_tag}, 32'b10011);
    chk("cnt_5", dbg_commit_cnt, 5 * CNT_EN);

    // Flush with same-cycle commit and issue
    issue(5'd1, 5'b10101); step();
    issue(5'd2, 5'b10110); step();
    issue(5'd3, 5'b10111); step(); idle_inputs();
    clr = 1; commit(5'd1, 32'h40, 5'b10101); issue(5'd6, 5'b11000);
    step(); idle_inputs();
    dc_to_reg_rs1 = 1; dc_to_reg_rs2 = 2; #1;
    chk("flush_x1_val", rs1_val, 32'h40);
    chk("flush_x1_busy", {31'd0, rs1_busy}, 0);
    chk("flush_x2_busy", {31'd0, rs2_busy}, 0);
    dc_to_reg_rs1 = 3; dc_to_reg_rs2 = 6; #1;
    chk("flush_x3_busy", {31'd0, rs1_busy}, 0);
    chk("flush_x3_tag", {27'd0, rs1_tag}, 0);
    chk("flush_x6_busy", {31'd0, rs2_busy}, 0);
    dc_to_reg_rs1 = 4; dc_to_reg_rs2 = 8; #1;
    chk("flush_x4_busy", {31'd0, rs1_busy}, 0);
    chk("flush_x4_val", rs1_val, 9);
    chk("flush_x8_busy", {31'd0, rs2_busy}, 0);
    chk("cnt_6", dbg_commit_cnt, 6 * CNT_EN);

    // x0 stays zero
    issue(5'd0, 5'b11111); commit(5'd0, 32'hFF, 5'b11111);
    dc_to_reg_rs1 = 0; #1;
    chk("x0_byp_val", rs1_val, 0);
    step(); idle_inputs(); #1;
    chk("x0_val", rs1_val, 0);
    chk("x0_busy", {31'd0, rs1_busy}, 0);
    chk("x0_cnt", dbg_commit_cnt, 6 * CNT_EN);

    // rdy low holds state
    rdy = 0; commit(5'd2, 32'd5, 5'b00000); issue(5'd9, 5'b10001);
    dc_to_reg_rs1 = 2; dc_to_reg_rs2 = 9;
    step(); #1;
    chk("rdy0_x2_val", rs1_val, 0);
    chk("rdy0_x9_busy", {31'd0, rs2_busy}, 0);
    chk("rdy0_cnt", dbg_commit_cnt, 6 * CNT_EN);
    rdy = 1; issue_to_reg_enable = 0;
    step(); idle_inputs(); #1;
    chk("rdy1_x2_val", rs1_val, 5);
    chk("rdy1_cnt", dbg_commit_cnt, 7 * CNT_EN);

    // Reset in the middle clears everything, with priority over rdy=0
    rdy = 0; rst = 0; step(); rst = 1; rdy = 1; #1;
    chk("rst2_x2_val", rs1_val, 0);
    chk("rst2_cnt", dbg_commit_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
